// File: rtl/phase_seq_decoder_if.sv
// Phase-bus monitor signal bundle: raw phase lines and control pulses in,
// decoded position, step and status flags out.
interface phase_seq_decoder_if #(
    parameter int POS_WIDTH = 16
);
    logic [3:0]           PhaseIn;
    logic                 PhaseEn;
    logic                 ClrPos;
    logic                 ClrErr;
    logic [POS_WIDTH-1:0] Position;
    logic                 StepPulse;
    logic                 StepDir;
    logic                 HalfMode;
    logic                 Locked;
    logic                 Idle;
    logic                 ErrIllegal;
    logic                 ErrSkip;

    modport master (
        output PhaseIn, PhaseEn, ClrPos, ClrErr,
        input  Position, StepPulse, StepDir, HalfMode, Locked, Idle, ErrIllegal, ErrSkip
    );

    modport slave (
        input  PhaseIn, PhaseEn, ClrPos, ClrErr,
        output Position, StepPulse, StepDir, HalfMode, Locked, Idle, ErrIllegal, ErrSkip
    );
endinterface

// File: rtl/phase_seq_decoder.sv
// Stepper phase-bus monitor: synchronises and glitch-filters the 4 phase lines,
// decodes the 8-code half-step sequence and tracks a signed half-step position.
module phase_seq_decoder #(
    parameter int POS_WIDTH     = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic               Clk,
    input  logic               nReset,
    phase_seq_decoder_if.slave bus
);

    localparam int                   CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);
    localparam logic [POS_WIDTH-1:0] POS_ONE = POS_WIDTH'(1);
    localparam logic [POS_WIDTH-1:0] POS_TWO = POS_WIDTH'(2);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2
    } state_t;

    // Synchroniser: {PhaseEn, PhaseIn} shifted through SYNC_STAGES flops
    logic [SYNC_STAGES-1:0][4:0] sync_q;
    logic [SYNC_STAGES-1:0][4:0] sync_d;
    logic                        sync_en;
    logic [3:0]                  sync_code;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], {bus.PhaseEn, bus.PhaseIn}};
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_en   = sync_q[SYNC_STAGES-1][4];
    assign sync_code = sync_q[SYNC_STAGES-1][3:0];

    // Glitch filter
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       acc_code_q, acc_code_d;
    logic             acc_valid_q, acc_valid_d;
    logic             acc_stb_q, acc_stb_d;
    logic             same_code;
    logic             run_hit;

    always_comb begin
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        acc_code_d  = acc_code_q;
        acc_valid_d = acc_valid_q;
        acc_stb_d   = 1'b0;
        same_code   = (cnt_q != '0) && (sync_code == cand_q);
        run_hit     = 1'b0;

        if (!sync_en) begin
            cand_d      = '0;
            cnt_d       = '0;
            acc_code_d  = '0;
            acc_valid_d = 1'b0;
        end else begin
            if (same_code) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else begin
                cand_d = sync_code;
                cnt_d  = CNT_ONE;
            end

            // A run fires once, on the cycle it first reaches full length;
            // a return to the already-accepted code is not a new event.
            run_hit = (cnt_d == CNT_MAX) && !(same_code && (cnt_q == CNT_MAX));
            if (run_hit && (!acc_valid_q || (cand_d != acc_code_q))) begin
                acc_stb_d   = 1'b1;
                acc_code_d  = cand_d;
                acc_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            cand_q      <= '0;
            cnt_q       <= '0;
            acc_code_q  <= '0;
            acc_valid_q <= 1'b0;
            acc_stb_q   <= 1'b0;
        end else begin
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            acc_code_q  <= acc_code_d;
            acc_valid_q <= acc_valid_d;
            acc_stb_q   <= acc_stb_d;
        end
    end

    // Sequence table lookup of the accepted code
    logic       dec_legal;
    logic [2:0] dec_idx;

    always_comb begin
        dec_legal = 1'b1;
        dec_idx   = 3'd0;
        case (acc_code_q)
            4'b0110: dec_idx = 3'd0;
            4'b0010: dec_idx = 3'd1;
            4'b1010: dec_idx = 3'd2;
            4'b1000: dec_idx = 3'd3;
            4'b1001: dec_idx = 3'd4;
            4'b0001: dec_idx = 3'd5;
            4'b0101: dec_idx = 3'd6;
            4'b0100: dec_idx = 3'd7;
            default: dec_legal = 1'b0;
        endcase
    end

    // Tracking state machine
    state_t               state_q, state_d;
    logic [2:0]           ref_q, ref_d;
    logic [POS_WIDTH-1:0] pos_q, pos_d;
    logic                 pulse_q, pulse_d;
    logic                 dir_q, dir_d;
    logic                 half_q, half_d;
    logic                 ill_q, ill_d;
    logic                 skip_q, skip_d;
    logic                 ill_set;
    logic                 skip_set;
    logic [2:0]           step_delta;

    always_comb begin
        state_d    = state_q;
        ref_d      = ref_q;
        pos_d      = pos_q;
        pulse_d    = 1'b0;
        dir_d      = dir_q;
        half_d     = half_q;
        ill_set    = 1'b0;
        skip_set   = 1'b0;
        step_delta = dec_idx - ref_q;

        if (!sync_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (acc_stb_q) begin
                        if (dec_legal) begin
                            ref_d   = dec_idx;
                            state_d = ST_TRACK;
                        end else begin
                            ill_set = 1'b1;
                        end
                    end
                end
                ST_TRACK: begin
                    if (acc_stb_q) begin
                        if (!dec_legal) begin
                            ill_set = 1'b1;
                            state_d = ST_ACQUIRE;
                        end else begin
                            ref_d = dec_idx;
                            case (step_delta)
                                3'd1: begin
                                    pos_d   = pos_q + POS_ONE;
                                    pulse_d = 1'b1;
                                    dir_d   = 1'b1;
                                    half_d  = 1'b1;
                                end
                                3'd2: begin
                                    pos_d   = pos_q + POS_TWO;
                                    pulse_d = 1'b1;
                                    dir_d   = 1'b1;
                                    half_d  = 1'b0;
                                end
                                3'd7: begin
                                    pos_d   = pos_q - POS_ONE;
                                    pulse_d = 1'b1;
                                    dir_d   = 1'b0;
                                    half_d  = 1'b1;
                                end
                                3'd6: begin
                                    pos_d   = pos_q - POS_TWO;
                                    pulse_d = 1'b1;
                                    dir_d   = 1'b0;
                                    half_d  = 1'b0;
                                end
                                3'd3, 3'd4, 3'd5: begin
                                    skip_set = 1'b1;
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Clear beats a coincident step; a coincident error beats clear
        if (bus.ClrPos) begin
            pos_d = '0;
        end
        ill_d  = (ill_q  & ~bus.ClrErr) | ill_set;
        skip_d = (skip_q & ~bus.ClrErr) | skip_set;
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state_q <= ST_IDLE;
            ref_q   <= '0;
            pos_q   <= '0;
            pulse_q <= 1'b0;
            dir_q   <= 1'b0;
            half_q  <= 1'b0;
            ill_q   <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            pos_q   <= pos_d;
            pulse_q <= pulse_d;
            dir_q   <= dir_d;
            half_q  <= half_d;
            ill_q   <= ill_d;
            skip_q  <= skip_d;
        end
    end

    assign bus.Position   = pos_q;
    assign bus.StepPulse  = pulse_q;
    assign bus.StepDir    = dir_q;
    assign bus.HalfMode   = half_q;
    assign bus.Locked     = (state_q == ST_TRACK);
    assign bus.Idle       = (state_q == ST_IDLE);
    assign bus.ErrIllegal = ill_q;
    assign bus.ErrSkip    = skip_q;

endmodule

// File: tb/tb_phase_seq_decoder.sv
// Directed bench for phase_seq_decoder: a 16-bit instance for the main checks and
// an 8-bit instance sharing the same stimulus to exercise position wrap cheaply.
module tb_phase_seq_decoder;

    logic Clk = 1'b0;
    logic nReset = 1'b0;
    always #5 Clk = ~Clk;

    phase_seq_decoder_if #(.POS_WIDTH(16)) bus ();
    phase_seq_decoder_if #(.POS_WIDTH(8))  bus_n ();

    assign bus_n.PhaseIn = bus.PhaseIn;
    assign bus_n.PhaseEn = bus.PhaseEn;
    assign bus_n.ClrPos  = bus.ClrPos;
    assign bus_n.ClrErr  = bus.ClrErr;

    phase_seq_decoder #(.POS_WIDTH(16), .SYNC_STAGES(2), .STABLE_CYCLES(4)) u_dut (
        .Clk    (Clk),
        .nReset (nReset),
        .bus    (bus)
    );

    phase_seq_decoder #(.POS_WIDTH(8), .SYNC_STAGES(2), .STABLE_CYCLES(4)) u_dut_n (
        .Clk    (Clk),
        .nReset (nReset),
        .bus    (bus_n)
    );

    int vectors = 0;
    int miscompares = 0;
    int pulse_cnt = 0;

    always @(negedge Clk) begin
        if (bus.StepPulse === 1'b1) pulse_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic hold(input logic [3:0] code, input int n);
        bus.PhaseIn = code;
        tick(n);
    endtask

    task automatic pulse_clrpos();
        bus.ClrPos = 1'b1;
        tick(1);
        bus.ClrPos = 1'b0;
    endtask

    task automatic test_reset();
        int p0;
        nReset = 1'b0;
        bus.PhaseEn = 1'b1;
        bus.PhaseIn = 4'b0110;
        tick(3);
        vectors++; if (bus.Idle !== 1'b1) begin $display("FAIL rst_idle: got %b want 1", bus.Idle); miscompares++; end
        vectors++; if (bus.Locked !== 1'b0) begin $display("FAIL rst_locked: got %b want 0", bus.Locked); miscompares++; end
        vectors++; if (bus.Position !== 16'h0000) begin $display("FAIL rst_pos: got %h want 0000", bus.Position); miscompares++; end
        vectors++; if (bus.StepPulse !== 1'b0) begin $display("FAIL rst_pulse: got %b want 0", bus.StepPulse); miscompares++; end
        vectors++; if ({bus.ErrIllegal, bus.ErrSkip} !== 2'b00) begin $display("FAIL rst_err: got %b want 00", {bus.ErrIllegal, bus.ErrSkip}); miscompares++; end
        nReset = 1'b1;
        p0 = pulse_cnt;
        tick(20);
        vectors++; if (bus.Locked !== 1'b1) begin $display("FAIL acq_locked: got %b want 1", bus.Locked); miscompares++; end
        vectors++; if (bus.Idle !== 1'b0) begin $display("FAIL acq_idle: got %b want 0", bus.Idle); miscompares++; end
        vectors++; if (pulse_cnt - p0 !== 0) begin $display("FAIL acq_pulses: got %0d want 0", pulse_cnt - p0); miscompares++; end
        vectors++; if (bus.Position !== 16'h0000) begin $display("FAIL acq_pos: got %h want 0000", bus.Position); miscompares++; end
        $display("test_reset done");
    endtask

    task automatic test_latency();
        bus.PhaseIn = 4'b0010;
        tick(6);
        vectors++; if (bus.StepPulse !== 1'b0) begin $display("FAIL lat_early: got %b want 0", bus.StepPulse); miscompares++; end
        tick(1);
        vectors++; if (bus.StepPulse !== 1'b1) begin $display("FAIL lat_pulse: got %b want 1", bus.StepPulse); miscompares++; end
        vectors++; if (bus.Position !== 16'h0001) begin $display("FAIL lat_pos: got %h want 0001", bus.Position); miscompares++; end
        tick(1);
        vectors++; if (bus.StepPulse !== 1'b0) begin $display("FAIL lat_width: got %b want 0", bus.StepPulse); miscompares++; end
        tick(12);
        hold(4'b0110, 20);
        vectors++; if (bus.Position !== 16'h0000) begin $display("FAIL ccw_half_pos: got %h want 0000", bus.Position); miscompares++; end
        vectors++; if ({bus.StepDir, bus.HalfMode} !== 2'b01) begin $display("FAIL ccw_half_mode: got %b want 01", {bus.StepDir, bus.HalfMode}); miscompares++; end
        $display("test_latency done");
    endtask

    task automatic test_cw_half();
        logic [3:0] seq [8];
        int p0;
        seq = '{4'b0010, 4'b1010, 4'b1000, 4'b1001, 4'b0001, 4'b0101, 4'b0100, 4'b0110};
        p0 = pulse_cnt;
        for (int i = 0; i < 8; i++) hold(seq[i], 20);
        vectors++; if (pulse_cnt - p0 !== 8) begin $display("FAIL cw_pulses: got %0d want 8", pulse_cnt - p0); miscompares++; end
        vectors++; if (bus.Position !== 16'h0008) begin $display("FAIL cw_pos: got %h want 0008", bus.Position); miscompares++; end
        vectors++; if ({bus.StepDir, bus.HalfMode} !== 2'b11) begin $display("FAIL cw_mode: got %b want 11", {bus.StepDir, bus.HalfMode}); miscompares++; end
        $display("test_cw_half done");
    endtask

    task automatic test_ccw_full();
        int p0;
        pulse_clrpos();
        vectors++; if (bus.Position !== 16'h0000) begin $display("FAIL clrpos: got %h want 0000", bus.Position); miscompares++; end
        p0 = pulse_cnt;
        hold(4'b0101, 20);
        hold(4'b1001, 20);
        hold(4'b1010, 20);
        vectors++; if (pulse_cnt - p0 !== 3) begin $display("FAIL ccw_pulses: got %0d want 3", pulse_cnt - p0); miscompares++; end
        vectors++; if (bus.Position !== 16'hFFFA) begin $display("FAIL ccw_pos: got %h want fffa", bus.Position); miscompares++; end
        vectors++; if ({bus.StepDir, bus.HalfMode} !== 2'b00) begin $display("FAIL ccw_mode: got %b want 00", {bus.StepDir, bus.HalfMode}); miscompares++; end
        $display("test_ccw_full done");
    endtask

    task automatic test_glitch();
        int p0;
        hold(4'b0110, 20);
        vectors++; if (bus.Position !== 16'hFFF8) begin $display("FAIL back_pos: got %h want fff8", bus.Position); miscompares++; end
        pulse_clrpos();
        p0 = pulse_cnt;
        hold(4'b1010, 3);
        hold(4'b0110, 20);
        vectors++; if (pulse_cnt - p0 !== 0) begin $display("FAIL glitch3_pulses: got %0d want 0", pulse_cnt - p0); miscompares++; end
        vectors++; if (bus.Position !== 16'h0000) begin $display("FAIL glitch3_pos: got %h want 0000", bus.Position); miscompares++; end
        hold(4'b1010, 4);
        bus.PhaseIn = 4'b0110;
        tick(3);
        vectors++; if (bus.StepPulse !== 1'b1) begin $display("FAIL glitch4_pulse: got %b want 1", bus.StepPulse); miscompares++; end
        vectors++; if (bus.Position !== 16'h0002) begin $display("FAIL glitch4_pos: got %h want 0002", bus.Position); miscompares++; end
        vectors++; if ({bus.StepDir, bus.HalfMode} !== 2'b10) begin $display("FAIL glitch4_mode: got %b want 10", {bus.StepDir, bus.HalfMode}); miscompares++; end
        tick(17);
        vectors++; if (bus.Position !== 16'h0000) begin $display("FAIL glitch4_ret: got %h want 0000", bus.Position); miscompares++; end
        $display("test_glitch done");
    endtask

    task automatic test_skip_illegal();
        int p0;
        p0 = pulse_cnt;
        hold(4'b1001, 20);
        vectors++; if ({bus.ErrSkip, bus.ErrIllegal} !== 2'b10) begin $display("FAIL skip4_err: got %b want 10", {bus.ErrSkip, bus.ErrIllegal}); miscompares++; end
        vectors++; if (bus.Locked !== 1'b1) begin $display("FAIL skip4_locked: got %b want 1", bus.Locked); miscompares++; end
        hold(4'b1111, 20);
        vectors++; if (bus.ErrIllegal !== 1'b1) begin $display("FAIL ill_err: got %b want 1", bus.ErrIllegal); miscompares++; end
        vectors++; if (bus.Locked !== 1'b0) begin $display("FAIL ill_locked: got %b want 0", bus.Locked); miscompares++; end
        bus.ClrErr = 1'b1;
        tick(1);
        bus.ClrErr = 1'b0;
        vectors++; if ({bus.ErrSkip, bus.ErrIllegal} !== 2'b00) begin $display("FAIL clrerr: got %b want 00", {bus.ErrSkip, bus.ErrIllegal}); miscompares++; end
        hold(4'b0110, 20);
        vectors++; if (bus.Locked !== 1'b1) begin $display("FAIL reacq_locked: got %b want 1", bus.Locked); miscompares++; end
        hold(4'b1000, 20);
        vectors++; if (bus.ErrSkip !== 1'b1) begin $display("FAIL skip3_err: got %b want 1", bus.ErrSkip); miscompares++; end
        bus.ClrErr = 1'b1;
        tick(1);
        bus.ClrErr = 1'b0;
        bus.PhaseIn = 4'b0110;
        tick(6);
        bus.ClrErr = 1'b1;
        tick(1);
        bus.ClrErr = 1'b0;
        vectors++; if (bus.ErrSkip !== 1'b1) begin $display("FAIL skip5_setwins: got %b want 1", bus.ErrSkip); miscompares++; end
        tick(13);
        vectors++; if (pulse_cnt - p0 !== 0) begin $display("FAIL skip_pulses: got %0d want 0", pulse_cnt - p0); miscompares++; end
        vectors++; if (bus.Position !== 16'h0000) begin $display("FAIL skip_pos: got %h want 0000", bus.Position); miscompares++; end
        vectors++; if ({bus.StepDir, bus.HalfMode} !== 2'b00) begin $display("FAIL skip_mode: got %b want 00", {bus.StepDir, bus.HalfMode}); miscompares++; end
        $display("test_skip_illegal done");
    endtask

    task automatic test_clrpos_step();
        bus.PhaseIn = 4'b0010;
        tick(6);
        bus.ClrPos = 1'b1;
        tick(1);
        bus.ClrPos = 1'b0;
        vectors++; if (bus.StepPulse !== 1'b1) begin $display("FAIL clrstep_pulse: got %b want 1", bus.StepPulse); miscompares++; end
        vectors++; if (bus.Position !== 16'h0000) begin $display("FAIL clrstep_pos: got %h want 0000", bus.Position); miscompares++; end
        tick(13);
        vectors++; if ({bus.StepDir, bus.HalfMode} !== 2'b11) begin $display("FAIL clrstep_mode: got %b want 11", {bus.StepDir, bus.HalfMode}); miscompares++; end
        $display("test_clrpos_step done");
    endtask

    task automatic test_wrap_idle();
        logic [3:0] full_seq [4];
        int p0;
        full_seq = '{4'b1001, 4'b0101, 4'b0110, 4'b1010};
        pulse_clrpos();
        p0 = pulse_cnt;
        hold(4'b1010, 8);
        for (int k = 0; k < 63; k++) hold(full_seq[k % 4], 8);
        tick(12);
        vectors++; if (bus_n.Position !== 8'h7F) begin $display("FAIL wrap_pre_n: got %h want 7f", bus_n.Position); miscompares++; end
        vectors++; if (bus.Position !== 16'h007F) begin $display("FAIL wrap_pre: got %h want 007f", bus.Position); miscompares++; end
        hold(4'b0010, 20);
        vectors++; if (bus_n.Position !== 8'h80) begin $display("FAIL wrap_n: got %h want 80", bus_n.Position); miscompares++; end
        vectors++; if (bus.Position !== 16'h0080) begin $display("FAIL wrap_wide: got %h want 0080", bus.Position); miscompares++; end
        vectors++; if (pulse_cnt - p0 !== 65) begin $display("FAIL wrap_pulses: got %0d want 65", pulse_cnt - p0); miscompares++; end
        bus.PhaseEn = 1'b0;
        tick(10);
        vectors++; if ({bus.Idle, bus.Locked} !== 2'b10) begin $display("FAIL idle_state: got %b want 10", {bus.Idle, bus.Locked}); miscompares++; end
        p0 = pulse_cnt;
        hold(4'b1010, 20);
        vectors++; if (bus.Position !== 16'h0080) begin $display("FAIL idle_pos: got %h want 0080", bus.Position); miscompares++; end
        vectors++; if ({bus.StepDir, bus.HalfMode} !== 2'b11) begin $display("FAIL idle_mode: got %b want 11", {bus.StepDir, bus.HalfMode}); miscompares++; end
        bus.PhaseEn = 1'b1;
        tick(20);
        vectors++; if (bus.Locked !== 1'b1) begin $display("FAIL reen_locked: got %b want 1", bus.Locked); miscompares++; end
        vectors++; if (pulse_cnt - p0 !== 0) begin $display("FAIL reen_pulses: got %0d want 0", pulse_cnt - p0); miscompares++; end
        vectors++; if (bus.Position !== 16'h0080) begin $display("FAIL reen_pos: got %h want 0080", bus.Position); miscompares++; end
        $display("test_wrap_idle done");
    endtask

    task automatic test_reset_midrun();
        bus.PhaseIn = 4'b1001;
        tick(3);
        nReset = 1'b0;
        tick(2);
        vectors++; if ({bus.Idle, bus.Locked} !== 2'b10) begin $display("FAIL rst2_state: got %b want 10", {bus.Idle, bus.Locked}); miscompares++; end
        vectors++; if (bus.Position !== 16'h0000) begin $display("FAIL rst2_pos: got %h want 0000", bus.Position); miscompares++; end
        vectors++; if ({bus.StepDir, bus.HalfMode, bus.ErrSkip} !== 3'b000) begin $display("FAIL rst2_flags: got %b want 000", {bus.StepDir, bus.HalfMode, bus.ErrSkip}); miscompares++; end
        nReset = 1'b1;
        tick(20);
        vectors++; if (bus.Locked !== 1'b1) begin $display("FAIL rst2_relock: got %b want 1", bus.Locked); miscompares++; end
        vectors++; if (bus.Position !== 16'h0000) begin $display("FAIL rst2_nostep: got %h want 0000", bus.Position); miscompares++; end
        $display("test_reset_midrun done");
    endtask

    initial begin
        bus.PhaseIn = 4'b0110;
        bus.PhaseEn = 1'b1;
        bus.ClrPos  = 1'b0;
        bus.ClrErr  = 1'b0;
        test_reset();
        test_latency();
        test_cw_half();
        test_ccw_full();
        test_glitch();
        test_skip_illegal();
        test_clrpos_step();
        test_wrap_idle();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
